// File: rtl/cpu_if_pkg.sv
// Shared definitions for the CPU bus front end of the CAN register file.
package cpu_if_pkg;

  // Front-end FSM state encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    ACK   = 3'd4
  } state_e;

  // Register file map (CPU-writable window is RX_ID_LO..INTERRUPT_REG)
  localparam logic [4:0] INTERRUPT_REG = 5'h12;
  localparam logic [4:0] ACCMASK_HI    = 5'h11;
  localparam logic [4:0] ACCMASK_LO    = 5'h10;
  localparam logic [4:0] ACCCODE_HI    = 5'h0F;
  localparam logic [4:0] ACCCODE_LO    = 5'h0E;
  localparam logic [4:0] BITTIMING     = 5'h0D;
  localparam logic [4:0] TX_DATA_HI    = 5'h0B;
  localparam logic [4:0] TX_DATA_LO    = 5'h08;
  localparam logic [4:0] RX_ID_HI      = 5'h05;
  localparam logic [4:0] RX_ID_LO      = 5'h04;

  localparam logic [4:0] ADDR_LO_DEF = RX_ID_LO;
  localparam logic [4:0] ADDR_HI_DEF = INTERRUPT_REG;

  // True when addr lies in the inclusive writable window [lo, hi]
  function automatic logic addr_in_range(input logic [4:0] addr,
                                         input logic [4:0] lo,
                                         input logic [4:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous CPU strobes.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clock) begin
    if (!reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
    end
  end

  assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/cpu_write_ctrl.sv
// CPU strobe front end: synchronizes cs/wr/rd, latches address/data and
// issues single-cycle write activation / read request pulses with a held ack.
module cpu_write_ctrl
  import cpu_if_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 16,
  parameter logic [4:0]  ADDR_LO     = ADDR_LO_DEF,
  parameter logic [4:0]  ADDR_HI     = ADDR_HI_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [4:0]        cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [4:0]        address,
  output logic [DATA_W-1:0] writedata,
  output logic              activ_in,
  output logic              read_req,
  output logic              ready,
  output logic              write_error
);

  logic cs_s, wr_s, rd_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clock(clock), .reset(reset), .din(cpu_cs), .dout(cs_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clock(clock), .reset(reset), .din(cpu_wr), .dout(wr_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clock(clock), .reset(reset), .din(cpu_rd), .dout(rd_s)
  );

  state_e            state_q, state_d;
  logic              dir_wr_q;
  logic              latch_en;
  logic [4:0]        address_q;
  logic [DATA_W-1:0] writedata_q;
  logic              activ_q, activ_d;
  logic              read_req_q, read_req_d;
  logic              ready_q, ready_d;
  logic              werr_q, werr_d;

  // State, latched bus values and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      dir_wr_q    <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      activ_q     <= 1'b0;
      read_req_q  <= 1'b0;
      ready_q     <= 1'b0;
      werr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      activ_q    <= activ_d;
      read_req_q <= read_req_d;
      ready_q    <= ready_d;
      werr_q     <= werr_d;
      if (latch_en) begin
        address_q   <= cpu_address;
        writedata_q <= cpu_writedata;
        dir_wr_q    <= wr_s;
      end
    end
  end

  // Next-state decode; a new access is only accepted from IDLE
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_s && (wr_s ^ rd_s)) begin
          state_d  = LATCH;
          latch_en = 1'b1;
        end else if (cs_s && wr_s && rd_s) begin
          state_d = ACK;
        end
      end
      LATCH:   state_d = dir_wr_q ? WRITE : READ;
      WRITE:   state_d = ACK;
      READ:    state_d = ACK;
      ACK: begin
        if (!cs_s || (!wr_s && !rd_s)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, registered so each output is valid for whole cycles.
  // address_q already holds the latched value whenever state_d is WRITE.
  always_comb begin
    activ_d    = 1'b0;
    read_req_d = (state_d == READ);
    ready_d    = (state_d == ACK);
    werr_d     = werr_q;
    if (state_d == WRITE) begin
      activ_d = addr_in_range(address_q, ADDR_LO, ADDR_HI);
      werr_d  = !addr_in_range(address_q, ADDR_LO, ADDR_HI);
    end
  end

  assign address     = address_q;
  assign writedata   = writedata_q;
  assign activ_in    = activ_q;
  assign read_req    = read_req_q;
  assign ready       = ready_q;
  assign write_error = werr_q;

endmodule
